// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: register-file geometry and dump FSM encoding shared by the debug blocks
package mips_debug_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;
endpackage

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: control, register-file read port and output stream of the dump reader
interface reg_dump_reader_if
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
);
    logic                  Start;
    logic                  Abort;
    logic [ADDR_WIDTH-1:0] FirstReg;
    logic [ADDR_WIDTH-1:0] LastReg;
    logic [ADDR_WIDTH-1:0] DumpReadReg;
    logic [DATA_WIDTH-1:0] DumpReadData;
    logic                  OutValid;
    logic                  OutReady;
    logic [ADDR_WIDTH-1:0] OutIndex;
    logic [DATA_WIDTH-1:0] OutData;
    logic                  Busy;
    logic                  Done;

    modport master (
        input  Start, Abort, FirstReg, LastReg, DumpReadData, OutReady,
        output DumpReadReg, OutValid, OutIndex, OutData, Busy, Done
    );

    modport slave (
        output Start, Abort, FirstReg, LastReg, DumpReadData, OutReady,
        input  DumpReadReg, OutValid, OutIndex, OutData, Busy, Done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register index range through a spare read port and
// streams (index, data) pairs over valid/ready
module reg_dump_reader
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int NUM_REGS   = mips_debug_pkg::NUM_REGS
) (
    input  logic               clk,
    input  logic               reset,
    reg_dump_reader_if.master  bus
);
    dump_state_t           r_state;
    dump_state_t           w_next;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  w_xfer;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_cur_inc;

    assign w_xfer    = r_valid && bus.OutReady;
    assign w_last    = r_cur == r_end;
    assign w_cur_inc = (r_cur == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : r_cur + 1'b1;

    // Abort wins over everything except reset; Start with Abort in IDLE is dropped
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (bus.Start && !bus.Abort) ? READ : IDLE;
        else if (bus.Abort)
            w_next = IDLE;
        else if (r_state == READ)
            w_next = HOLD;
        else if (r_state == HOLD)
            w_next = w_xfer ? (w_last ? DONE : READ) : HOLD;
        else
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_end   <= '0;
            r_index <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_next == HOLD;
            if (r_state == IDLE && w_next == READ) begin
                r_cur <= bus.FirstReg;
                r_end <= bus.LastReg;
            end
            if (r_state == HOLD && w_next == READ)
                r_cur <= w_cur_inc;
            if (r_state == READ && w_next == HOLD) begin
                r_index <= r_cur;
                r_data  <= bus.DumpReadData;
            end
        end
    end

    assign bus.DumpReadReg = r_cur;
    assign bus.OutValid    = r_valid;
    assign bus.OutIndex    = r_index;
    assign bus.OutData     = r_data;
    assign bus.Busy        = r_state != IDLE;
    assign bus.Done        = r_state == DONE;
endmodule
